// File: rtl/ps2_key_tracker.sv
// PS/2 Set-2 key tracker: parses E0/F0 prefixes, follows the held key with typematic
// suppression, counts distinct presses and drives active-low hex seven-segment digits.
module ps2_key_tracker #(
    parameter int unsigned CNT_W            = 8,
    parameter int unsigned BLANK_ON_RELEASE = 1,
    parameter int unsigned TIMEOUT          = 1000000
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        code_valid,
    input  logic [7:0]                  code,
    output logic [7:0]                  key_code,
    output logic                        key_ext,
    output logic                        key_down,
    output logic [CNT_W-1:0]            press_cnt,
    output logic                        proto_err,
    output logic [7*(2+CNT_W/4)-1:0]    seg
);

    localparam int unsigned NDIG    = 2 + CNT_W / 4;
    localparam int unsigned SEG_W   = 7 * NDIG;
    localparam int unsigned CDIG    = CNT_W / 4;
    localparam int unsigned TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [7:0] B_EXT = 8'hE0;
    localparam logic [7:0] B_BRK = 8'hF0;
    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t              state, state_nxt;
    logic [TO_W-1:0]     to_cnt, to_cnt_nxt;
    logic [7:0]          key_code_nxt;
    logic                key_ext_nxt;
    logic                key_down_nxt;
    logic [CNT_W-1:0]    press_cnt_nxt;
    logic                proto_err_nxt;
    logic [SEG_W-1:0]    seg_nxt;
    logic [SEG_W-1:0]    seg_rst;

    logic                do_make;
    logic                do_brk;
    logic                ev_ext;

    // Active-low hex glyph, bits {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Host-protocol and keyboard status bytes carry no key information
    function automatic logic is_ignored(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
               (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
    endfunction

    // Prefix parser, timeout and key tracking
    always_comb begin
        state_nxt     = state;
        to_cnt_nxt    = to_cnt;
        key_code_nxt  = key_code;
        key_ext_nxt   = key_ext;
        key_down_nxt  = key_down;
        press_cnt_nxt = press_cnt;
        proto_err_nxt = 1'b0;
        do_make       = 1'b0;
        do_brk        = 1'b0;
        ev_ext        = 1'b0;

        if (code_valid) begin
            to_cnt_nxt = '0;
            case (state)
                S_IDLE: begin
                    if (code == B_EXT)          state_nxt = S_EXT;
                    else if (code == B_BRK)     state_nxt = S_BRK;
                    else if (!is_ignored(code)) do_make = 1'b1;
                end
                S_EXT: begin
                    if (code == B_BRK)      state_nxt = S_EXT_BRK;
                    else if (code != B_EXT) begin
                        do_make   = 1'b1;
                        ev_ext    = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                S_BRK, S_EXT_BRK: begin
                    state_nxt = S_IDLE;
                    if (code == B_EXT || code == B_BRK) begin
                        proto_err_nxt = 1'b1;
                    end else begin
                        do_brk = 1'b1;
                        ev_ext = (state == S_EXT_BRK);
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (TIMEOUT > 0 && state != S_IDLE) begin
            if (to_cnt == TO_W'(TO_LAST)) begin
                state_nxt     = S_IDLE;
                proto_err_nxt = 1'b1;
                to_cnt_nxt    = '0;
            end else begin
                to_cnt_nxt = to_cnt + TO_W'(1);
            end
        end else begin
            to_cnt_nxt = '0;
        end

        // A make matching the held key is typematic repeat and changes nothing
        if (do_make && !(key_down && code == key_code && ev_ext == key_ext)) begin
            key_code_nxt  = code;
            key_ext_nxt   = ev_ext;
            key_down_nxt  = 1'b1;
            press_cnt_nxt = press_cnt + CNT_W'(1);
        end
        if (do_brk && code == key_code && ev_ext == key_ext) begin
            key_down_nxt = 1'b0;
        end
    end

    // Display digits from the registered key state
    always_comb begin
        seg_nxt = '1;
        seg_rst = '1;
        for (int i = 0; i < int'(CDIG); i++) begin
            seg_nxt[7*(2+i) +: 7] = hex7(press_cnt[4*i +: 4]);
            seg_rst[7*(2+i) +: 7] = hex7(4'h0);
        end
        if (BLANK_ON_RELEASE != 0 && !key_down) begin
            seg_nxt[13:0] = {BLANK, BLANK};
        end else begin
            seg_nxt[6:0]  = hex7(key_code[3:0]);
            seg_nxt[13:7] = hex7(key_code[7:4]);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= S_IDLE;
            to_cnt    <= '0;
            key_code  <= '0;
            key_ext   <= 1'b0;
            key_down  <= 1'b0;
            press_cnt <= '0;
            proto_err <= 1'b0;
            seg       <= seg_rst;
        end else begin
            state     <= state_nxt;
            to_cnt    <= to_cnt_nxt;
            key_code  <= key_code_nxt;
            key_ext   <= key_ext_nxt;
            key_down  <= key_down_nxt;
            press_cnt <= press_cnt_nxt;
            proto_err <= proto_err_nxt;
            seg       <= seg_nxt;
        end
    end

endmodule
